// File: rtl/sm_mem_arbiter_if.sv
// Bundle of both master request ports, the shared slave port and the busy flag.
// The arbiter connects through "master"; the environment (masters plus slave) through "slave".
interface sm_mem_arbiter_if;
    logic        m0_valid;
    logic [31:0] m0_a;
    logic        m0_we;
    logic [31:0] m0_wd;
    logic        m0_ready;
    logic        m0_err;
    logic [31:0] m0_rd;

    logic        m1_valid;
    logic [31:0] m1_a;
    logic        m1_we;
    logic [31:0] m1_wd;
    logic        m1_ready;
    logic        m1_err;
    logic [31:0] m1_rd;

    logic        s_valid;
    logic [31:0] s_a;
    logic        s_we;
    logic [31:0] s_wd;
    logic        s_ready;
    logic [31:0] s_rd;

    logic        busy;

    // Handshake: a master raises m*_valid and holds a/we/wd stable until its one-cycle
    // m*_ready strobe (m*_err marks an abort). Toward the slave, s_valid is shown only in
    // ISSUE; s_ready there is acceptance, and the first s_ready in WAIT is completion.
    modport master (
        input  m0_valid, m0_a, m0_we, m0_wd,
        input  m1_valid, m1_a, m1_we, m1_wd,
        input  s_ready, s_rd,
        output m0_ready, m0_err, m0_rd,
        output m1_ready, m1_err, m1_rd,
        output s_valid, s_a, s_we, s_wd,
        output busy
    );

    modport slave (
        output m0_valid, m0_a, m0_we, m0_wd,
        output m1_valid, m1_a, m1_we, m1_wd,
        output s_ready, s_rd,
        input  m0_ready, m0_err, m0_rd,
        input  m1_ready, m1_err, m1_rd,
        input  s_valid, s_a, s_we, s_wd,
        input  busy
    );
endinterface

// File: rtl/sm_mem_arbiter.sv
// Two-master, one-slave arbiter for the valid/ready RAM port, with a watchdog that
// aborts a transaction whose slave never accepts or never completes.
module sm_mem_arbiter #(
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    sm_mem_arbiter_if.master      bus,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam bit         TMO_EN    = (TIMEOUT != 0);
    localparam logic [7:0] TMO_LIMIT = TMO_EN ? 8'(TIMEOUT - 1) : 8'd0;

    state_e     state_q, state_d;
    logic       grant_q, grant_d;   // 0 = m0, 1 = m1
    logic       last_q,  last_d;    // master served by the last completed transaction
    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    logic       in_flight;
    logic       completion;
    logic       timeout_hit;
    logic       done;
    logic       pick;

    assign in_flight   = (state_q != ST_IDLE);
    assign completion  = (state_q == ST_WAIT) && bus.s_ready;
    assign timeout_hit = TMO_EN && in_flight && !completion && (tmo_cnt_q == TMO_LIMIT);
    // A reset cycle must never leak a strobe to the masters.
    assign done        = (completion || timeout_hit) && !rst;

    always_comb begin
        pick = bus.m1_valid;
        if (bus.m0_valid && bus.m1_valid) begin
            pick = ROUND_ROBIN ? ~last_q : 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        tmo_cnt_d = tmo_cnt_q;

        if (in_flight && !completion && (tmo_cnt_q != 8'hFF)) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                tmo_cnt_d = 8'd0;
                if (bus.m0_valid || bus.m1_valid) begin
                    grant_d = pick;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (timeout_hit) begin
                    state_d = ST_IDLE;
                end else if (bus.s_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (completion) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b0;
            tmo_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    always_comb begin
        bus.s_valid  = 1'b0;
        bus.s_a      = 32'd0;
        bus.s_we     = 1'b0;
        bus.s_wd     = 32'd0;
        bus.m0_ready = 1'b0;
        bus.m0_err   = 1'b0;
        bus.m0_rd    = 32'd0;
        bus.m1_ready = 1'b0;
        bus.m1_err   = 1'b0;
        bus.m1_rd    = 32'd0;

        if (in_flight) begin
            bus.s_valid = (state_q == ST_ISSUE);
            bus.s_a     = grant_q ? bus.m1_a  : bus.m0_a;
            bus.s_we    = grant_q ? bus.m1_we : bus.m0_we;
            bus.s_wd    = grant_q ? bus.m1_wd : bus.m0_wd;
        end

        // Read data is forwarded only on a genuine completion; aborts return zero.
        if (done) begin
            if (grant_q) begin
                bus.m1_ready = 1'b1;
                bus.m1_err   = timeout_hit;
                bus.m1_rd    = timeout_hit ? 32'd0 : bus.s_rd;
            end else begin
                bus.m0_ready = 1'b1;
                bus.m0_err   = timeout_hit;
                bus.m0_rd    = timeout_hit ? 32'd0 : bus.s_rd;
            end
        end
    end

    assign bus.busy    = in_flight;
    assign dbg_state_o = state_q;

endmodule
